ram_programmer: RTL and testbench

RAM_PROGRAMMER -- requirements
Module: ram_programmer

---
 rtl/ram_programmer.sv | 236 +++++++++++++++++++++++
 tb/tb_ram_programmer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_programmer.sv
`timescale 1ns/1ps
// UART-fed RAM loader: waits for a magic byte sequence, then streams little-endian
// 32-bit words out as address/data/valid while holding the system in reset.
module ram_programmer #(
    parameter int unsigned               CLK_FREQ     = 50_000_000,
    parameter int unsigned               BAUD_RATE    = 115200,
    parameter int unsigned               SEQ_LENGTH   = 8,
    parameter logic [8*SEQ_LENGTH-1:0]   MAGIC_SEQ    = "CERESTST",
    parameter int unsigned               BREAK_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_rx_i,
    output logic [31:0] prog_addr_o,
    output logic [31:0] prog_data_o,
    output logic        prog_valid_o,
    output logic        prog_mode_o,
    output logic        system_reset_o
);

    localparam int unsigned DIV    = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF   = DIV / 2;
    localparam int unsigned BAUD_W = $clog2(DIV + 1);
    localparam int unsigned TO_W   = $clog2(BREAK_CYCLES + 1);
    localparam int unsigned IDX_W  = (SEQ_LENGTH > 1) ? $clog2(SEQ_LENGTH) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {SYNC, COUNT, DATA} ctl_state_t;

    // Magic sequence unpacked so that element 0 is the first expected byte
    logic [7:0] w_magic [SEQ_LENGTH];
    for (genvar g = 0; g < SEQ_LENGTH; g++) begin : g_magic
        assign w_magic[g] = MAGIC_SEQ[8*(SEQ_LENGTH-1-g) +: 8];
    end

    // ---------------- receiver ----------------
    logic              r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t         r_rx_state, w_rx_state_nxt;
    logic [BAUD_W-1:0] r_baud_cnt, w_baud_cnt_nxt;
    logic [2:0]        r_bit_idx, w_bit_idx_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              r_byte_valid, w_byte_valid_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_rx_meta    <= uart_rx_i;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_rx_state   <= w_rx_state_nxt;
            r_baud_cnt   <= w_baud_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_byte_valid_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_baud_cnt_nxt   = r_baud_cnt + BAUD_W'(1);
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_byte_valid_nxt = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_baud_cnt_nxt = '0;
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                // A line that is high again at mid-start was only a glitch
                if (r_baud_cnt == BAUD_W'(HALF - 1)) begin
                    w_baud_cnt_nxt = '0;
                    w_bit_idx_nxt  = '0;
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_baud_cnt == BAUD_W'(DIV - 1)) begin
                    w_baud_cnt_nxt = '0;
                    w_shift_nxt    = {r_rx_sync, r_shift[7:1]};
                    w_bit_idx_nxt  = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_baud_cnt == BAUD_W'(DIV - 1)) begin
                    w_baud_cnt_nxt   = '0;
                    w_byte_valid_nxt = r_rx_sync;
                    w_rx_state_nxt   = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // ---------------- control ----------------
    ctl_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_match_idx, w_match_idx_nxt;
    logic [1:0]       r_byte_cnt, w_byte_cnt_nxt;
    logic [31:0]      r_word, w_word_nxt;
    logic [31:0]      r_word_count, w_word_count_nxt;
    logic [31:0]      r_addr_cnt, w_addr_cnt_nxt;
    logic [TO_W-1:0]  r_timeout, w_timeout_nxt;
    logic [31:0]      r_prog_addr, w_prog_addr_nxt;
    logic [31:0]      r_prog_data, w_prog_data_nxt;
    logic             r_prog_valid, w_prog_valid_nxt;
    logic             r_prog_mode, w_prog_mode_nxt;
    logic             r_system_reset;
    logic [31:0]      w_word_asm, w_count_asm;

    // Bytes shift in from the top so the first byte of four lands in [7:0]
    assign w_word_asm  = {r_shift, r_word[31:8]};
    assign w_count_asm = {r_shift, r_word_count[31:8]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= SYNC;
            r_match_idx    <= '0;
            r_byte_cnt     <= '0;
            r_word         <= '0;
            r_word_count   <= '0;
            r_addr_cnt     <= '0;
            r_timeout      <= '0;
            r_prog_addr    <= '0;
            r_prog_data    <= '0;
            r_prog_valid   <= 1'b0;
            r_prog_mode    <= 1'b0;
            r_system_reset <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_match_idx    <= w_match_idx_nxt;
            r_byte_cnt     <= w_byte_cnt_nxt;
            r_word         <= w_word_nxt;
            r_word_count   <= w_word_count_nxt;
            r_addr_cnt     <= w_addr_cnt_nxt;
            r_timeout      <= w_timeout_nxt;
            r_prog_addr    <= w_prog_addr_nxt;
            r_prog_data    <= w_prog_data_nxt;
            r_prog_valid   <= w_prog_valid_nxt;
            r_prog_mode    <= w_prog_mode_nxt;
            r_system_reset <= w_prog_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_match_idx_nxt  = r_match_idx;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_word_nxt       = r_word;
        w_word_count_nxt = r_word_count;
        w_addr_cnt_nxt   = r_addr_cnt;
        w_timeout_nxt    = '0;
        w_prog_addr_nxt  = r_prog_addr;
        w_prog_data_nxt  = r_prog_data;
        w_prog_valid_nxt = 1'b0;
        w_prog_mode_nxt  = r_prog_mode;
        case (r_state)
            SYNC: begin
                if (r_byte_valid) begin
                    if (r_shift == w_magic[r_match_idx]) begin
                        if (r_match_idx == IDX_W'(SEQ_LENGTH - 1)) begin
                            w_state_nxt     = COUNT;
                            w_match_idx_nxt = '0;
                            w_byte_cnt_nxt  = '0;
                            w_prog_mode_nxt = 1'b1;
                        end else begin
                            w_match_idx_nxt = r_match_idx + IDX_W'(1);
                        end
                    end else begin
                        w_match_idx_nxt = (r_shift == w_magic[0]) ? IDX_W'(1) : '0;
                    end
                end
            end
            COUNT, DATA: begin
                if (r_byte_valid) begin
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_state == COUNT) begin
                        w_word_count_nxt = w_count_asm;
                        if (r_byte_cnt == 2'd3) begin
                            w_addr_cnt_nxt = '0;
                            if (w_count_asm == 32'd0) begin
                                w_state_nxt     = SYNC;
                                w_prog_mode_nxt = 1'b0;
                            end else begin
                                w_state_nxt = DATA;
                            end
                        end
                    end else begin
                        w_word_nxt = w_word_asm;
                        if (r_byte_cnt == 2'd3) begin
                            w_prog_data_nxt  = w_word_asm;
                            w_prog_addr_nxt  = r_addr_cnt;
                            w_prog_valid_nxt = 1'b1;
                            w_addr_cnt_nxt   = r_addr_cnt + 32'd1;
                            if (r_addr_cnt == r_word_count - 32'd1) begin
                                w_state_nxt     = SYNC;
                                w_prog_mode_nxt = 1'b0;
                            end
                        end
                    end
                end else if (r_timeout == TO_W'(BREAK_CYCLES - 1)) begin
                    // Sender went quiet: drop any partial word and resynchronise
                    w_state_nxt     = SYNC;
                    w_match_idx_nxt = '0;
                    w_byte_cnt_nxt  = '0;
                    w_prog_mode_nxt = 1'b0;
                end else begin
                    w_timeout_nxt = r_timeout + TO_W'(1);
                end
            end
            default: begin
                w_state_nxt     = SYNC;
                w_prog_mode_nxt = 1'b0;
            end
        endcase
    end

    assign prog_addr_o    = r_prog_addr;
    assign prog_data_o    = r_prog_data;
    assign prog_valid_o   = r_prog_valid;
    assign prog_mode_o    = r_prog_mode;
    assign system_reset_o = r_system_reset;

endmodule

// File: tb/tb_ram_programmer.sv
`timescale 1ns/1ps
// Self-checking bench for ram_programmer: directed scenarios plus randomized streams
// checked against a byte-stream level reference model.
module tb_ram_programmer;

    localparam int unsigned DIV   = 10;
    localparam int unsigned BREAK = 500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [31:0] addr, data;
    logic        valid, mode, sysrst;

    int checks = 0;
    int errors = 0;

    logic [63:0] q_got[$];
    logic [63:0] q_exp[$];
    logic        prev_valid = 1'b0;

    logic [7:0] magic [4] = '{8'h50, 8'h52, 8'h4F, 8'h47};

    ram_programmer #(
        .CLK_FREQ    (1_000_000),
        .BAUD_RATE   (100_000),
        .SEQ_LENGTH  (4),
        .MAGIC_SEQ   (32'h50524F47),
        .BREAK_CYCLES(BREAK)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .uart_rx_i     (rx),
        .prog_addr_o   (addr),
        .prog_data_o   (data),
        .prog_valid_o  (valid),
        .prog_mode_o   (mode),
        .system_reset_o(sysrst)
    );

    always #5 clk = ~clk;

    // Output monitor: collects pulses, checks pulse width and reset mirroring
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (sysrst !== mode) begin
                errors++;
                if (errors < 20) $display("FAIL sysrst_eq_mode: system_reset_o=%b prog_mode_o=%b", sysrst, mode);
            end
            if (valid === 1'b1) begin
                q_got.push_back({addr, data});
                checks++;
                if (prev_valid === 1'b1) begin
                    errors++;
                    $display("FAIL valid_width: prog_valid_o high for more than 1 cycle at addr %0d", addr);
                end
            end
            prev_valid = valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- reference model (byte-stream level) ----------------
    int          m_state;   // 0 hunting for magic, 1 reading count, 2 reading words
    int          m_idx;
    int          m_nbytes;
    int          m_addr;
    logic [31:0] m_cnt, m_word;

    function automatic void model_reset();
        m_state = 0; m_idx = 0; m_nbytes = 0; m_addr = 0; m_cnt = '0; m_word = '0;
    endfunction

    function automatic void model_timeout();
        if (m_state != 0) begin
            m_state = 0;
            m_idx   = 0;
        end
    endfunction

    function automatic void model_feed(input logic [7:0] b, input logic stop);
        if (!stop) return;
        if (m_state == 0) begin
            if (b == magic[m_idx]) begin
                m_idx++;
                if (m_idx == 4) begin
                    m_state = 1; m_idx = 0; m_nbytes = 0;
                end
            end else begin
                m_idx = (b == magic[0]) ? 1 : 0;
            end
        end else if (m_state == 1) begin
            m_cnt[8*m_nbytes +: 8] = b;
            m_nbytes++;
            if (m_nbytes == 4) begin
                m_nbytes = 0;
                m_addr   = 0;
                m_state  = (m_cnt == 32'd0) ? 0 : 2;
            end
        end else begin
            m_word[8*m_nbytes +: 8] = b;
            m_nbytes++;
            if (m_nbytes == 4) begin
                q_exp.push_back({32'(m_addr), m_word});
                m_addr++;
                m_nbytes = 0;
                if (32'(m_addr) == m_cnt) m_state = 0;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (DIV) @(negedge clk);
    endtask

    task automatic tx(input logic [7:0] b, input logic stop = 1'b1);
        model_feed(b, stop);
        send_byte(b, stop);
    endtask

    task automatic tx_magic();
        for (int i = 0; i < 4; i++) tx(magic[i]);
    endtask

    task automatic tx_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) tx(w[8*i +: 8]);
    endtask

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 3) == 0) return magic[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks += 5;
        if (addr !== 32'd0)  begin errors++; $display("FAIL reset_addr: got %h expected 0", addr); end
        if (data !== 32'd0)  begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
        if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        if (mode !== 1'b0)   begin errors++; $display("FAIL reset_mode: got %b expected 0", mode); end
        if (sysrst !== 1'b0) begin errors++; $display("FAIL reset_sysrst: got %b expected 0", sysrst); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (mode !== 1'b0) begin errors++; $display("FAIL post_reset_mode: got %b expected 0", mode); end
    endtask

    task automatic test_basic();
        q_got.delete();
        tx_magic();
        repeat (5) @(negedge clk);
        checks += 2;
        if (mode !== 1'b1)   begin errors++; $display("FAIL basic_mode_on: got %b expected 1", mode); end
        if (sysrst !== 1'b1) begin errors++; $display("FAIL basic_sysrst_on: got %b expected 1", sysrst); end
        tx_word(32'd2);
        tx_word(32'h1234_5678);
        repeat (5) @(negedge clk);
        checks += 3;
        if (q_got.size() != 1) begin errors++; $display("FAIL basic_count1: got %0d pulses expected 1", q_got.size()); end
        if (q_got[0] !== {32'd0, 32'h1234_5678}) begin errors++; $display("FAIL basic_word0: got %h expected %h", q_got[0], {32'd0, 32'h1234_5678}); end
        if (mode !== 1'b1) begin errors++; $display("FAIL basic_mode_mid: got %b expected 1", mode); end
        tx_word(32'hDEAD_BEEF);
        repeat (5) @(negedge clk);
        checks += 3;
        if (q_got.size() != 2) begin errors++; $display("FAIL basic_count2: got %0d pulses expected 2", q_got.size()); end
        if (q_got[1] !== {32'd1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL basic_word1: got %h expected %h", q_got[1], {32'd1, 32'hDEAD_BEEF}); end
        if (mode !== 1'b0) begin errors++; $display("FAIL basic_mode_off: got %b expected 0", mode); end
        repeat (50) @(negedge clk);
        checks += 2;
        if (addr !== 32'd1)          begin errors++; $display("FAIL basic_addr_hold: got %h expected 1", addr); end
        if (data !== 32'hDEAD_BEEF)  begin errors++; $display("FAIL basic_data_hold: got %h expected deadbeef", data); end
    endtask

    task automatic test_pprog();
        q_got.delete();
        tx(8'h50); tx(8'h50); tx(8'h52); tx(8'h4F);
        repeat (5) @(negedge clk);
        checks++;
        if (mode !== 1'b0) begin errors++; $display("FAIL pprog_early: got %b expected 0", mode); end
        tx(8'h47);
        repeat (5) @(negedge clk);
        checks++;
        if (mode !== 1'b1) begin errors++; $display("FAIL pprog_mode_on: got %b expected 1", mode); end
        tx_word(32'd0);
        repeat (5) @(negedge clk);
        checks += 2;
        if (mode !== 1'b0)     begin errors++; $display("FAIL pprog_mode_off: got %b expected 0", mode); end
        if (q_got.size() != 0) begin errors++; $display("FAIL pprog_no_pulse: got %0d pulses expected 0", q_got.size()); end
    endtask

    task automatic test_mismatch();
        q_got.delete();
        tx(8'h50); tx(8'h52); tx(8'h58); tx(8'h47);
        repeat (20) @(negedge clk);
        checks += 2;
        if (mode !== 1'b0)     begin errors++; $display("FAIL prxg_mode: got %b expected 0", mode); end
        if (q_got.size() != 0) begin errors++; $display("FAIL prxg_no_pulse: got %0d pulses expected 0", q_got.size()); end
    endtask

    task automatic test_timeout();
        q_got.delete();
        tx_magic();
        tx_word(32'd1);
        tx(8'hAA);
        repeat (100) @(negedge clk);
        checks++;
        if (mode !== 1'b1) begin errors++; $display("FAIL timeout_before: got %b expected 1", mode); end
        repeat (500) @(negedge clk);
        model_timeout();
        checks += 2;
        if (mode !== 1'b0)     begin errors++; $display("FAIL timeout_mode: got %b expected 0", mode); end
        if (q_got.size() != 0) begin errors++; $display("FAIL timeout_no_pulse: got %0d pulses expected 0", q_got.size()); end
    endtask

    task automatic test_bad_stop();
        q_got.delete();
        tx(8'h50); tx(8'h52); tx(8'h4F, 1'b0); tx(8'h47);
        repeat (20) @(negedge clk);
        checks++;
        if (mode !== 1'b0) begin errors++; $display("FAIL badstop_mode: got %b expected 0", mode); end
        tx_magic();
        repeat (5) @(negedge clk);
        checks++;
        if (mode !== 1'b1) begin errors++; $display("FAIL badstop_full_match: got %b expected 1", mode); end
        tx_word(32'd1);
        tx_word(32'h4433_2211);
        repeat (5) @(negedge clk);
        checks += 3;
        if (q_got.size() != 1) begin errors++; $display("FAIL badstop_count: got %0d pulses expected 1", q_got.size()); end
        if (q_got[0] !== {32'd0, 32'h4433_2211}) begin errors++; $display("FAIL badstop_word: got %h expected %h", q_got[0], {32'd0, 32'h4433_2211}); end
        if (mode !== 1'b0) begin errors++; $display("FAIL badstop_mode_off: got %b expected 0", mode); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int unsigned nw;
            int unsigned nj;
            q_got.delete();
            q_exp.delete();
            nj = $urandom_range(0, 3);
            for (int j = 0; j < int'(nj); j++) begin
                tx(rand_byte(), ($urandom_range(0, 7) != 0));
                repeat ($urandom_range(0, 2) * DIV) @(negedge clk);
            end
            tx_magic();
            nw = $urandom_range(1, 3);
            tx_word(32'(nw));
            for (int j = 0; j < int'(4 * nw); j++) begin
                tx(rand_byte());
                repeat ($urandom_range(0, 2) * DIV) @(negedge clk);
            end
            repeat (5) @(negedge clk);
            checks += 2;
            if (mode !== (m_state != 0)) begin errors++; $display("FAIL rand_mode[%0d]: got %b expected %b", it, mode, (m_state != 0)); end
            if (q_got.size() != q_exp.size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d pulses expected %0d", it, q_got.size(), q_exp.size()); end
            for (int k = 0; k < q_exp.size(); k++) begin
                checks++;
                if (k >= q_got.size() || q_got[k] !== q_exp[k]) begin
                    errors++;
                    $display("FAIL rand_word[%0d.%0d]: got %h expected %h", it, k, (k < q_got.size()) ? q_got[k] : 64'hx, q_exp[k]);
                end
            end
            repeat (BREAK + 100) @(negedge clk);
            model_timeout();
        end
    endtask

    task automatic test_reset_mid();
        q_got.delete();
        tx_magic();
        tx_word(32'd2);
        tx_word(32'h0403_0201);
        rx = 1'b0;
        repeat (25) @(negedge clk);
        checks += 2;
        if (mode !== 1'b1)     begin errors++; $display("FAIL rstmid_mode_before: got %b expected 1", mode); end
        if (q_got.size() != 1) begin errors++; $display("FAIL rstmid_first_word: got %0d pulses expected 1", q_got.size()); end
        #1 rst_n = 1'b0;
        #1;
        checks += 5;
        if (addr !== 32'd0)  begin errors++; $display("FAIL rstmid_addr: got %h expected 0", addr); end
        if (data !== 32'd0)  begin errors++; $display("FAIL rstmid_data: got %h expected 0", data); end
        if (valid !== 1'b0)  begin errors++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
        if (mode !== 1'b0)   begin errors++; $display("FAIL rstmid_mode: got %b expected 0", mode); end
        if (sysrst !== 1'b0) begin errors++; $display("FAIL rstmid_sysrst: got %b expected 0", sysrst); end
        rx = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        q_got.delete();
        tx_magic();
        tx_word(32'd1);
        tx_word(32'h00EE_FFC0);
        repeat (5) @(negedge clk);
        checks += 3;
        if (q_got.size() != 1) begin errors++; $display("FAIL rstmid_after_count: got %0d pulses expected 1", q_got.size()); end
        if (q_got[0] !== {32'd0, 32'h00EE_FFC0}) begin errors++; $display("FAIL rstmid_after_word: got %h expected %h", q_got[0], {32'd0, 32'h00EE_FFC0}); end
        if (mode !== 1'b0) begin errors++; $display("FAIL rstmid_after_mode: got %b expected 0", mode); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_pprog();
        test_mismatch();
        test_timeout();
        test_bad_stop();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
